// File: rtl/wall_lookup_arbiter.sv
// Round-robin arbiter sharing one registered maze wall-lookup unit
// among pacman (index 0) and the ghosts.
module wall_lookup_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int LOOKUP_LATENCY = 1
) (
  input  logic                   clk_50mhz,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [9*NUM_REQ-1:0]   req_x,
  input  logic [9*NUM_REQ-1:0]   req_y,
  output logic [NUM_REQ-1:0]     grant,
  output logic [NUM_REQ-1:0]     ack,
  output logic [11:0]            resp_flags,
  output logic                   busy,
  output logic [8:0]             lk_x,
  output logic [8:0]             lk_y,
  input  logic [2:0]             lk_flag_L,
  input  logic [2:0]             lk_flag_U,
  input  logic [2:0]             lk_flag_R,
  input  logic [2:0]             lk_flag_D
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOOKUP_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state, state_n;

  logic [IW-1:0]      last, last_n;
  logic [CW-1:0]      cnt, cnt_n;
  logic [NUM_REQ-1:0] grant_n, ack_n;
  logic [11:0]        resp_n;
  logic               busy_n;
  logic [8:0]         x_n, y_n;

  logic [IW-1:0]      cand;
  logic [IW-1:0]      win_idx;
  logic               win_vld;

  // Search last+1, last+2, ... with wrap-around; first set bit wins.
  always_comb begin
    cand    = last;
    win_idx = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (cand == IW'(NUM_REQ - 1)) ? '0 : cand + 1'b1;
      if (!win_vld && req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    grant_n = grant;
    ack_n   = '0;
    resp_n  = resp_flags;
    busy_n  = busy;
    x_n     = lk_x;
    y_n     = lk_y;
    unique case (state)
      IDLE: begin
        if (win_vld) begin
          x_n     = req_x[9*win_idx +: 9];
          y_n     = req_y[9*win_idx +: 9];
          grant_n = NUM_REQ'(1) << win_idx;
          last_n  = win_idx;
          cnt_n   = CW'(LOOKUP_LATENCY);
          busy_n  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt != '0) begin
          cnt_n = cnt - 1'b1;
        end else begin
          resp_n  = {lk_flag_L, lk_flag_U,
                     lk_flag_R, lk_flag_D};
          ack_n   = grant;
          state_n = RESP;
        end
      end
      RESP: begin
        grant_n = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
      default: begin
        grant_n = '0;
        busy_n  = 1'b0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last       <= IW'(NUM_REQ - 1);
      cnt        <= '0;
      grant      <= '0;
      ack        <= '0;
      resp_flags <= '0;
      busy       <= 1'b0;
      lk_x       <= '0;
      lk_y       <= '0;
    end else begin
      state      <= state_n;
      last       <= last_n;
      cnt        <= cnt_n;
      grant      <= grant_n;
      ack        <= ack_n;
      resp_flags <= resp_n;
      busy       <= busy_n;
      lk_x       <= x_n;
      lk_y       <= y_n;
    end
  end

endmodule

// File: tb/tb_wall_lookup_arbiter.sv
// Bench for wall_lookup_arbiter: transaction-level model plus
// directed scenarios with literal expectations.
module tb_wall_lookup_arbiter;

  localparam int N   = 5;
  localparam int LAT = 1;

  logic           clk_50mhz = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [9*N-1:0] req_x, req_y;
  logic [N-1:0]   grant, ack;
  logic [11:0]    resp_flags;
  logic           busy;
  logic [8:0]     lk_x, lk_y;
  logic [2:0]     lk_flag_L, lk_flag_U, lk_flag_R, lk_flag_D;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  wall_lookup_arbiter #(.NUM_REQ(N), .LOOKUP_LATENCY(LAT)) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .req       (req),
    .req_x     (req_x),
    .req_y     (req_y),
    .grant     (grant),
    .ack       (ack),
    .resp_flags(resp_flags),
    .busy      (busy),
    .lk_x      (lk_x),
    .lk_y      (lk_y),
    .lk_flag_L (lk_flag_L),
    .lk_flag_U (lk_flag_U),
    .lk_flag_R (lk_flag_R),
    .lk_flag_D (lk_flag_D)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  // Wall-table stand-in: arbitrary but coordinate-dependent flags.
  function automatic logic [11:0] lut(input logic [8:0] x, input logic [8:0] y);
    return {x[2:0] ^ 3'd1, y[2:0] ^ 3'd6, x[5:3] + 3'd1, y[5:3] ^ 3'd4};
  endfunction

  always @(posedge clk_50mhz)
    {lk_flag_L, lk_flag_U, lk_flag_R, lk_flag_D} <= lut(lk_x, lk_y);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: age counts edges since the grant edge.
  int          m_age;
  int          m_last;
  logic [8:0]  m_x, m_y;
  logic [11:0] m_flags;
  logic [N-1:0] e_grant, e_ack;
  logic        e_busy;

  always @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      m_age = -1; m_last = N - 1;
      m_x = 0; m_y = 0; m_flags = 0;
      e_grant = 0; e_ack = 0; e_busy = 0;
    end else begin
      e_ack = 0;
      if (m_age < 0) begin
        bit found;
        found = 0;
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!found && req[c]) begin
            found = 1;
            m_last = c;
            m_age = 0;
            m_x = req_x[9*c +: 9];
            m_y = req_y[9*c +: 9];
            e_grant = N'(1) << c;
            e_busy = 1;
          end
        end
      end else begin
        m_age++;
        if (m_age == LAT + 1) begin
          m_flags = lut(m_x, m_y);
          e_ack = e_grant;
        end else if (m_age == LAT + 2) begin
          e_grant = 0;
          e_busy = 0;
          m_age = -1;
        end
      end
    end
  end

  always @(negedge clk_50mhz) begin
    if (chk_en) begin
      check("grant", 32'(grant), 32'(e_grant));
      check("ack", 32'(ack), 32'(e_ack));
      check("busy", 32'(busy), 32'(e_busy));
      check("resp_flags", 32'(resp_flags), 32'(m_flags));
      check("lk_x", 32'(lk_x), 32'(m_x));
      check("lk_y", 32'(lk_y), 32'(m_y));
    end
  end

  task automatic reset_dut();
    @(negedge clk_50mhz); #2;
    req = 0;
    rst = 1;
    @(negedge clk_50mhz); #2;
    rst = 0;
  endtask

  task automatic wait_any_ack(output int who, output int cyc);
    who = -1;
    cyc = 0;
    while (who < 0 && cyc < 40) begin
      @(negedge clk_50mhz);
      cyc++;
      for (int i = 0; i < N; i++)
        if (ack[i]) who = i;
    end
    if (who < 0) check("ack_timeout", 32'(cyc), 32'(0));
  endtask

  task automatic wait_grant(input logic [N-1:0] want);
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk_50mhz);
      cyc++;
    end while (((want == 0) ? (grant == 0) : (grant != want)) && cyc < 40);
    if (cyc >= 40) check("grant_timeout", 32'(grant), 32'(want));
  endtask

  initial begin
    int who, cyc, pulses, regrants;
    bit seen;
    rst = 0; req = 0; req_x = 0; req_y = 0;
    #3 rst = 1;
    chk_en = 1;
    repeat (2) @(negedge clk_50mhz);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_lk_x", 32'(lk_x), 32'd0);
    #2 rst = 0;

    // single pacman lookup
    req_x[8:0] = 9'd200;
    req_y[8:0] = 9'd230;
    req = 5'b00001;
    wait_any_ack(who, cyc);
    check("t1_who", 32'(who), 32'd0);
    check("t1_latency", 32'(cyc), 32'd3);
    check("t1_flags", 32'(resp_flags), 32'(12'b001_000_010_000));
    check("t1_lk_x", 32'(lk_x), 32'd200);
    check("t1_lk_y", 32'(lk_y), 32'd230);
    #2 req = 0;

    // all requesting: strict rotation, 4-cycle spacing
    reset_dut();
    for (int i = 0; i < N; i++) begin
      req_x[9*i +: 9] = 9'(i * 37 + 11);
      req_y[9*i +: 9] = 9'(i * 53 + 7);
    end
    req = '1;
    for (int n = 0; n < 6; n++) begin
      wait_any_ack(who, cyc);
      check("t2_order", 32'(who), 32'(n % N));
      check("t2_gap", 32'(cyc), (n == 0) ? 32'd3 : 32'd4);
    end

    // wrap-around search after a grant to 3
    reset_dut();
    req = 5'b01000;
    wait_any_ack(who, cyc);
    check("t3_who", 32'(who), 32'd3);
    #2 req = 5'b00100;
    wait_grant('0);
    check("t3_grant", 32'(grant), 32'(5'b00100));
    wait_any_ack(who, cyc);
    #2 req = 0;

    // coordinates sampled only at the grant edge
    reset_dut();
    req_x[9 +: 9] = 9'd100;
    req_y[9 +: 9] = 9'd50;
    req = 5'b00010;
    wait_grant('0);
    check("t4_lk_x_e0", 32'(lk_x), 32'd100);
    #2 req_x[9 +: 9] = 9'd120;
    wait_any_ack(who, cyc);
    check("t4_lk_x_ack", 32'(lk_x), 32'd100);
    #2 req = 0;
    repeat (3) @(negedge clk_50mhz);
    check("t4_lk_x_idle", 32'(lk_x), 32'd100);

    // async reset mid-transaction
    reset_dut();
    req = '1;
    wait_grant(5'b00010);
    #2 rst = 1;
    #1;
    check("t5_grant", 32'(grant), 32'd0);
    check("t5_ack", 32'(ack), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_lk_x", 32'(lk_x), 32'd0);
    check("t5_flags", 32'(resp_flags), 32'd0);
    @(negedge clk_50mhz); #2;
    rst = 0;
    wait_grant('0);
    check("t5_first", 32'(grant), 32'(5'b00001));
    wait_any_ack(who, cyc);
    #2 req = 0;

    // requester drops after grant: one ack, no re-grant
    reset_dut();
    req = 5'b01000;
    wait_grant('0);
    #2 req = 0;
    pulses = 0; regrants = 0; seen = 0;
    repeat (12) begin
      @(negedge clk_50mhz);
      if (seen && grant != 0) regrants++;
      if (ack[3]) begin
        pulses++;
        seen = 1;
      end
    end
    check("t6_pulses", 32'(pulses), 32'd1);
    check("t6_regrant", 32'(regrants), 32'd0);

    @(negedge clk_50mhz);
    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
